// File: rtl/ga21_pal_dma.sv
`default_nettype none
// ============================================================================
// Module   : ga21_pal_dma
// Purpose  : CPU-programmed DMA that copies 16-bit colour words from the
//            palette staging buffer into palette RAM over the GA21 port.
// Revision : 1.0
// ============================================================================
module ga21_pal_dma #(
    parameter int SRC_AW = 16,
    parameter int PAL_AW = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              cpu_reg_we,
    input  logic [1:0]        cpu_reg_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic [SRC_AW-1:0] src_addr,
    output logic              src_rd,
    input  logic [15:0]       src_data,
    output logic [PAL_AW-1:0] ga21_addr,
    output logic              ga21_we,
    output logic              ga21_req,
    output logic              dma_busy,
    output logic [15:0]       pal_dout,
    output logic              done_irq
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VB = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_AW-1:0]   src_q, cur_src_q, cur_src_d;
    logic [PAL_AW-1:0]   dst_q, len_q, cur_dst_q, cur_dst_d, rem_q, rem_d;
    logic                vb_prev_q;
    logic                done_q, done_d, aborted_q, aborted_d;
    logic                src_rd_q, ga21_we_q, ga21_req_q, dma_busy_q, done_irq_q;
    logic [SRC_AW-1:0]   src_addr_q;
    logic [PAL_AW-1:0]   ga21_addr_q;

    logic w_ctrl_wr, w_start, w_abort, w_vb_rise;

    assign w_ctrl_wr = cpu_reg_we && (cpu_reg_addr == 2'd3);
    assign w_start   = w_ctrl_wr && cpu_din[0];
    assign w_abort   = w_ctrl_wr && cpu_din[2];
    assign w_vb_rise = vblank && !vb_prev_q;

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        if (w_ctrl_wr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                // abort in the same write as start suppresses the start entirely
                if (w_start && !w_abort) begin
                    cur_src_d = src_q;
                    cur_dst_d = dst_q;
                    rem_d     = len_q;
                    if (len_q == '0)     state_d = DONE;
                    else if (cpu_din[1]) state_d = WAIT_VB;
                    else                 state_d = READ;
                end
            end
            WAIT_VB: begin
                if (w_abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (w_vb_rise) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (w_abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cur_src_d = cur_src_q + SRC_AW'(1);
                cur_dst_d = cur_dst_q + PAL_AW'(1);
                rem_d     = rem_q - PAL_AW'(1);
                if (w_abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (rem_q == PAL_AW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            rem_q       <= '0;
            vb_prev_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            src_rd_q    <= 1'b0;
            src_addr_q  <= '0;
            ga21_we_q   <= 1'b0;
            ga21_addr_q <= '0;
            ga21_req_q  <= 1'b0;
            dma_busy_q  <= 1'b0;
            done_irq_q  <= 1'b0;
        end else begin
            if (cpu_reg_we && cpu_reg_addr == 2'd0) src_q <= cpu_din[SRC_AW-1:0];
            if (cpu_reg_we && cpu_reg_addr == 2'd1) dst_q <= cpu_din[PAL_AW-1:0];
            if (cpu_reg_we && cpu_reg_addr == 2'd2) len_q <= cpu_din[PAL_AW-1:0];
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            rem_q       <= rem_d;
            vb_prev_q   <= vblank;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            src_rd_q    <= (state_d == READ);
            src_addr_q  <= (state_d == READ) ? cur_src_d : '0;
            ga21_we_q   <= (state_d == WRITE);
            ga21_addr_q <= (state_d == WRITE) ? cur_dst_d : '0;
            ga21_req_q  <= (state_d == READ) || (state_d == WRITE);
            dma_busy_q  <= (state_d != IDLE);
            done_irq_q  <= (state_q == DONE);
        end
    end

    always_comb begin
        cpu_dout = 16'h0000;
        case (cpu_reg_addr)
            2'd0:    cpu_dout = 16'(src_q);
            2'd1:    cpu_dout = 16'(dst_q);
            2'd2:    cpu_dout = 16'(len_q);
            default: cpu_dout = {13'd0, aborted_q, done_q, dma_busy_q};
        endcase
    end

    assign src_addr  = src_addr_q;
    assign src_rd    = src_rd_q;
    assign ga21_addr = ga21_addr_q;
    assign ga21_we   = ga21_we_q;
    assign ga21_req  = ga21_req_q;
    assign dma_busy  = dma_busy_q;
    assign done_irq  = done_irq_q;
    // Staging data arrives during WRITE, so it is forwarded rather than registered.
    assign pal_dout  = ga21_we_q ? src_data : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_ga21_pal_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ga21_pal_dma
// Purpose  : directed bench for ga21_pal_dma with a per-cycle timeline model.
// Revision : 1.0
// ============================================================================
module tb_ga21_pal_dma;
    localparam int MAXC = 4096;

    logic        clk = 1'b0, reset_n = 1'b0, vblank = 1'b0, cpu_reg_we = 1'b0;
    logic [1:0]  cpu_reg_addr = 2'd0;
    logic [15:0] cpu_din = 16'h0000;
    logic [15:0] cpu_dout, pal_dout, src_addr, src_data;
    logic [12:0] ga21_addr;
    logic        src_rd, ga21_we, ga21_req, dma_busy, done_irq;

    ga21_pal_dma #(.SRC_AW(16), .PAL_AW(13)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .cpu_reg_we(cpu_reg_we), .cpu_reg_addr(cpu_reg_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
        .ga21_addr(ga21_addr), .ga21_we(ga21_we), .ga21_req(ga21_req),
        .dma_busy(dma_busy), .pal_dout(pal_dout), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] buf_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    always @(posedge clk) src_data <= src_rd ? buf_word(src_addr) : 16'hDEAD;

    // Expected outputs per cycle index (cycle n = interval after the n-th posedge).
    logic        e_busy [MAXC];
    logic        e_we   [MAXC];
    logic        e_rd   [MAXC];
    logic        e_req  [MAXC];
    logic        e_irq  [MAXC];
    logic [15:0] e_raddr[MAXC];
    logic [15:0] e_waddr[MAXC];
    logic [15:0] e_wdata[MAXC];

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int from);
        for (int c = from; c < from + 300 && c < MAXC; c++) begin
            e_busy[c] = 1'b0; e_we[c] = 1'b0; e_rd[c] = 1'b0; e_req[c] = 1'b0;
            e_irq[c] = 1'b0; e_raddr[c] = '0; e_waddr[c] = '0; e_wdata[c] = '0;
        end
    endtask

    // Word i is read in cycle b+2i and written in b+2i+1; the end cycle is busy, irq follows.
    task automatic sched(input int b, input int len, input int src, input int dst);
        for (int i = 0; i < len; i++) begin
            int r = b + 2 * i;
            e_rd[r] = 1'b1; e_req[r] = 1'b1; e_busy[r] = 1'b1;
            e_raddr[r] = 16'((src + i) % 65536);
            e_we[r+1] = 1'b1; e_req[r+1] = 1'b1; e_busy[r+1] = 1'b1;
            e_waddr[r+1] = 16'((dst + i) % 8192);
            e_wdata[r+1] = buf_word(16'((src + i) % 65536));
        end
        e_busy[b + 2 * len] = 1'b1;
        e_irq[b + 2 * len + 1] = 1'b1;
    endtask

    typedef struct { logic [15:0] a; logic [15:0] d; int c; } wr_t;
    wr_t         wlog[$];
    logic [15:0] rlog[$];
    int          irq_c = -1, busy_n = 0;

    always @(posedge clk) begin
        #1;
        if (cyc < MAXC) begin
            check("dma_busy", 32'(dma_busy), 32'(e_busy[cyc]));
            check("ga21_we", 32'(ga21_we), 32'(e_we[cyc]));
            check("ga21_req", 32'(ga21_req), 32'(e_req[cyc]));
            check("src_rd", 32'(src_rd), 32'(e_rd[cyc]));
            check("done_irq", 32'(done_irq), 32'(e_irq[cyc]));
            check("src_addr", 32'(src_addr), 32'(e_raddr[cyc]));
            check("ga21_addr", 32'(ga21_addr), 32'(e_waddr[cyc]));
            check("pal_dout", 32'(pal_dout), 32'(e_wdata[cyc]));
        end
        if (ga21_we) wlog.push_back('{16'(ga21_addr), pal_dout, cyc});
        if (src_rd) rlog.push_back(src_addr);
        if (done_irq) irq_c = cyc;
        if (dma_busy) busy_n++;
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_reg_we = 1'b1; cpu_reg_addr = a; cpu_din = d;
        @(negedge clk);
        cpu_reg_we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [15:0] exp);
        @(negedge clk);
        cpu_reg_addr = a;
        #1;
        check(nm, 32'(cpu_dout), 32'(exp));
    endtask

    task automatic start(input logic [15:0] ctrl, input int len, input int src,
                         input int dst, output int e);
        @(negedge clk);
        cpu_reg_we = 1'b1; cpu_reg_addr = 2'd3; cpu_din = ctrl;
        e = cyc + 1;
        if (ctrl[1]) for (int c = e; c < e + 200; c++) e_busy[c] = 1'b1;
        else sched(e, len, src, dst);
        @(negedge clk);
        cpu_reg_we = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic reset_logs();
        wlog.delete(); rlog.delete(); irq_c = -1; busy_n = 0;
    endtask

    initial begin
        int e, v, a;
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int e, v, a;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 1'b0; e_we[c] = 1'b0; e_rd[c] = 1'b0; e_req[c] = 1'b0;
            e_irq[c] = 1'b0; e_raddr[c] = '0; e_waddr[c] = '0; e_wdata[c] = '0;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rd("reset_src", 2'd0, 16'h0000);
        rd("reset_ctrl", 2'd3, 16'h0000);

        // Basic 3-word copy
        wr(2'd0, 16'h0100); wr(2'd1, 16'h0200); wr(2'd2, 16'h0003);
        reset_logs();
        start(16'h0001, 3, 16'h0100, 16'h0200, e);
        repeat (10) @(negedge clk);
        check("t1_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("t1_addr0", 32'(wlog[0].a), 32'h0200);
            check("t1_addr2", 32'(wlog[2].a), 32'h0202);
            check("t1_data0", 32'(wlog[0].d), 32'h1100);
            check("t1_data2", 32'(wlog[2].d), 32'h1102);
            check("t1_spacing", 32'(wlog[1].c - wlog[0].c), 32'd2);
            check("t1_latency", 32'(wlog[0].c - e), 32'd1);
        end
        check("t1_irq_cyc", 32'(irq_c - e), 32'd7);
        rd("t1_status", 2'd3, 16'h0002);
        rd("t1_len", 2'd2, 16'h0003);

        // Zero-length transfer
        wr(2'd2, 16'h0000);
        reset_logs();
        start(16'h0001, 0, 0, 0, e);
        repeat (5) @(negedge clk);
        check("t2_nwrites", 32'(wlog.size()), 32'd0);
        check("t2_nreads", 32'(rlog.size()), 32'd0);
        check("t2_irq_cyc", 32'(irq_c - e), 32'd1);
        check("t2_busy_n", 32'(busy_n), 32'd1);

        // Vsync start with vblank already high; upper DST/LEN bits ignored
        wr(2'd0, 16'h0040); wr(2'd1, 16'hE010); wr(2'd2, 16'hE002);
        rd("t3_dst_rb", 2'd1, 16'h0010);
        vblank = 1'b1;
        repeat (2) @(negedge clk);
        reset_logs();
        start(16'h0003, 2, 16'h0040, 16'h0010, e);
        repeat (4) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_no_early_rd", 32'(rlog.size()), 32'd0);
        @(negedge clk);
        vblank = 1'b1;
        v = cyc + 1;
        for (int c = v; c < e + 200; c++) e_busy[c] = 1'b0;
        sched(v, 2, 16'h0040, 16'h0010);
        repeat (8) @(negedge clk);
        vblank = 1'b0;
        check("t3_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) check("t3_first_we", 32'(wlog[0].c - v), 32'd1);

        // Address wrap on both sides
        wr(2'd0, 16'hFFFF); wr(2'd1, 16'h1FFF); wr(2'd2, 16'h0002);
        reset_logs();
        start(16'h0001, 2, 16'hFFFF, 16'h1FFF, e);
        repeat (7) @(negedge clk);
        check("t4_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("t4_waddr1", 32'(wlog[1].a), 32'h0000);
            check("t4_wdata0", 32'(wlog[0].d), 32'h0FFF);
        end
        if (rlog.size() == 2) begin
            check("t4_raddr0", 32'(rlog[0]), 32'hFFFF);
            check("t4_raddr1", 32'(rlog[1]), 32'h0000);
        end

        // Abort landing in the READ of word 6
        wr(2'd0, 16'h0300); wr(2'd1, 16'h0500); wr(2'd2, 16'd100);
        reset_logs();
        start(16'h0001, 100, 16'h0300, 16'h0500, e);
        wait_until(e + 10);
        cpu_reg_we = 1'b1; cpu_reg_addr = 2'd3; cpu_din = 16'h0004;
        a = cyc + 1;
        clear_from(a);
        e_busy[a] = 1'b1;
        e_irq[a+1] = 1'b1;
        @(negedge clk);
        cpu_reg_we = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_nwrites", 32'(wlog.size()), 32'd5);
        check("t5_irq_cyc", 32'(irq_c - e), 32'd12);
        rd("t5_status", 2'd3, 16'h0006);
        wr(2'd3, 16'h0000);
        rd("t5_cleared", 2'd3, 16'h0000);

        // Abort together with start while idle: nothing happens
        wr(2'd3, 16'h0005);
        repeat (3) @(negedge clk);
        rd("t5b_status", 2'd3, 16'h0000);

        // Reset asserted in the middle of a WRITE
        wr(2'd0, 16'h0700); wr(2'd1, 16'h0800); wr(2'd2, 16'h0004);
        start(16'h0001, 4, 16'h0700, 16'h0800, e);
        wait_until(e + 3);
        reset_n = 1'b0;
        clear_from(e + 4);
        #1;
        check("t6_we_async", 32'(ga21_we), 32'd0);
        check("t6_req_async", 32'(ga21_req), 32'd0);
        check("t6_busy_async", 32'(dma_busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd("t6_src", 2'd0, 16'h0000);
        rd("t6_dst", 2'd1, 16'h0000);
        rd("t6_len", 2'd2, 16'h0000);
        rd("t6_ctrl", 2'd3, 16'h0000);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ga21_pal_dma.md
Name: ga21_pal_dma

Overview:
- Palette DMA engine for the GA21 path: copies a block of 16-bit colour words from the palette staging buffer into palette RAM.
- Drives the palette RAM's GA21 port and DMA indicators: ga21_addr, ga21_we, ga21_req, dma_busy, plus the write data.
- Sits directly upstream of the palette RAM block.
- The CPU programs it through a 4-register window; a transfer can start immediately or be synchronised to vblank start.

Parameters:
SRC_AW, 16, source (staging buffer) word address width
PAL_AW, 13, palette RAM word address width; also LEN/DST width

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
vblank  in  1  vertical blank, synchronous to clk
cpu_reg_we  in  1  register write strobe, one cycle
cpu_reg_addr  in  2  register select
cpu_din  in  16  register write data
cpu_dout  out  16  register read data, combinational from cpu_reg_addr
src_addr  out  SRC_AW  staging buffer read address
src_rd  out  1  staging buffer read strobe
src_data  in  16  staging buffer data, valid exactly 1 cycle after src_rd
ga21_addr  out  PAL_AW  palette RAM write address
ga21_we  out  1  palette RAM write enable
ga21_req  out  1  GA21 palette port request
dma_busy  out  1  transfer in progress
pal_dout  out  16  palette RAM write data
done_irq  out  1  one-cycle pulse when a transfer ends, normally or by abort

Behaviour:
- Register map:
  - 0 SRC[15:0]
  - 1 DST[12:0]
  - 2 LEN[12:0] (word count; 0 = no words)
  - 3 CTRL
- CTRL write bits: bit0 start, bit1 vsync mode, bit2 abort.
- CTRL read bits: bit0 busy, bit1 done (sticky), bit2 aborted (sticky), others 0.
- Any CTRL write clears done and aborted, then applies start/abort.
- Unused upper bits of DST and LEN are ignored on write and read as 0.
- Reset: all outputs 0; SRC, DST, LEN 0; state IDLE; sticky bits 0.
- States: IDLE, WAIT_VB, READ, WRITE, DONE.
- IDLE:
  - start=1, vsync=0 -> READ next cycle.
  - start=1, vsync=1 -> WAIT_VB.
  - Working counters load on start: cur_src=SRC, cur_dst=DST, remaining=LEN.
  - start with LEN=0 -> DONE directly; no palette write occurs.
- WAIT_VB: wait for a vblank rising edge (registered previous vblank), then -> READ.
  - vblank already high at start does not count; the next rising edge is required.
- READ: src_rd=1, src_addr=cur_src; -> WRITE.
- WRITE:
  - ga21_we=1, ga21_addr=cur_dst, pal_dout=src_data.
  - Then cur_src+1 (wraps mod 2^SRC_AW), cur_dst+1 (wraps mod 2^PAL_AW), remaining-1.
  - remaining reaching 0 -> DONE, else -> READ.
- DONE: done_irq=1 for one cycle; done sticky set; -> IDLE.
- Throughput: 2 clk per word. Latency from the start write to the first ga21_we is 2 cycles (READ then WRITE).
- dma_busy=1 in WAIT_VB, READ, WRITE, DONE; 0 in IDLE.
- ga21_req=1 in READ and WRITE only.
- ga21_addr and pal_dout are 0 and ga21_we is 0 outside WRITE.
- Writes to SRC, DST, LEN while busy update the registers only; the running counters are unaffected.
- start while busy is ignored.
- abort=1 in any non-IDLE state -> DONE next cycle:
  - no further ga21_we, including when the abort lands in READ;
  - aborted sticky set.
- abort and start in the same write while IDLE: abort wins; no transfer starts and nothing is flagged.
- SRC/DST/LEN registers persist after a transfer, so a repeat start re-copies the same block.
- reset_n low mid-transfer: immediate return to reset values; no partial-cycle writes after assertion.

Test Plan:
1. SRC=0x0100, DST=0x0200, LEN=3, CTRL=1 -> exactly 3 ga21_we pulses at 0x0200, 0x0201, 0x0202 carrying buffer words 0x0100–0x0102; 2 cycles apart; one done_irq pulse; status reads 0x0002.
2. LEN=0, CTRL=1 -> no ga21_we and no src_rd; done_irq 2 cycles after the write; dma_busy high for 1 cycle.
3. CTRL=3 with vblank already high -> dma_busy=1 but no src_rd until vblank falls and rises again; first ga21_we 2 cycles after the rising edge.
4. DST=0x1FFF, SRC=0xFFFF, LEN=2 -> writes at 0x1FFF then 0x0000, reads from 0xFFFF then 0x0000.
5. LEN=100, CTRL abort written after the 5th ga21_we -> no 6th write; done_irq pulses; status bit2=1; dma_busy drops within 2 cycles.
6. reset_n pulsed low during WRITE -> ga21_we, ga21_req, dma_busy drop asynchronously; after release all registers read 0 and state is IDLE.
